// File: rtl/wb_downsizer_if.sv
// rtl/wb_downsizer_if.sv - 32-bit master side and 8-bit slave side Wishbone signals of the downsizer
interface wb_downsizer_if #(
  parameter int aw = 32
);
  logic [aw-1:0] wbm_adr_i;
  logic [31:0]   wbm_dat_i;
  logic [3:0]    wbm_sel_i;
  logic          wbm_we_i;
  logic          wbm_cyc_i;
  logic          wbm_stb_i;
  logic [31:0]   wbm_dat_o;
  logic          wbm_ack_o;
  logic          wbm_err_o;

  logic [aw-1:0] wbs_adr_o;
  logic [7:0]    wbs_dat_o;
  logic          wbs_we_o;
  logic          wbs_cyc_o;
  logic          wbs_stb_o;
  logic [7:0]    wbs_dat_i;
  logic          wbs_ack_i;
  logic          wbs_err_i;

  // The downsizer itself.
  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  // The wide master together with the byte-wide slave around it.
  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );
endinterface

// File: rtl/wb_downsizer.sv
// rtl/wb_downsizer.sv - splits 32-bit classic Wishbone accesses into big-endian byte accesses
// Optional WB_DOWNSIZER_ERR_EN: slave error aborts the access and is reported on wbm_err_o.
module wb_downsizer #(
  parameter int aw = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  wb_downsizer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [aw-1:0] adr_q;
  logic [31:0]   dat_q;
  logic          we_q;
  logic [3:0]    pend_q;     // bit n set: byte at offset n still to be issued
  logic [31:0]   rdat_q;
  logic [1:0]    off;
  logic [3:0]    pend_nxt;
  logic          last_byte;
  logic          byte_done;
  logic [7:0]    wbyte;
  logic          start;
  logic          busy_live;
`ifdef WB_DOWNSIZER_ERR_EN
  logic          err_q;
  logic          slv_err;
`endif

  assign start     = bus.wbm_cyc_i & bus.wbm_stb_i;
  assign busy_live = (state == BUSY) & bus.wbm_cyc_i;

`ifdef WB_DOWNSIZER_ERR_EN
  assign byte_done = bus.wbs_ack_i;
  assign slv_err   = bus.wbs_err_i;
`else
  assign byte_done = bus.wbs_ack_i | bus.wbs_err_i;
`endif

  // Lowest pending offset goes first, giving ascending address order.
  always_comb begin
    off = 2'd3;
    if (pend_q[0])      off = 2'd0;
    else if (pend_q[1]) off = 2'd1;
    else if (pend_q[2]) off = 2'd2;
  end

  assign pend_nxt  = pend_q & ~(4'b0001 << off);
  assign last_byte = (pend_nxt == 4'b0000);

  always_comb begin
    wbyte = dat_q[7:0];
    case (off)
      2'd0:    wbyte = dat_q[31:24];
      2'd1:    wbyte = dat_q[23:16];
      2'd2:    wbyte = dat_q[15:8];
      default: wbyte = dat_q[7:0];
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (bus.wbm_sel_i != 4'b0000) ? BUSY : DONE;
      end
      BUSY: begin
        if (!bus.wbm_cyc_i)                state_nxt = IDLE;
`ifdef WB_DOWNSIZER_ERR_EN
        else if (slv_err)                  state_nxt = DONE;
`endif
        else if (byte_done && last_byte)   state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = 8'h00;
    bus.wbs_we_o  = 1'b0;
    bus.wbm_ack_o = 1'b0;
    bus.wbm_err_o = 1'b0;
    case (state)
      BUSY: begin
        bus.wbs_cyc_o = 1'b1;
        bus.wbs_stb_o = 1'b1;
        bus.wbs_adr_o = {adr_q[aw-1:2], off};
        bus.wbs_dat_o = wbyte;
        bus.wbs_we_o  = we_q;
      end
      DONE: begin
`ifdef WB_DOWNSIZER_ERR_EN
        bus.wbm_ack_o = ~err_q;
        bus.wbm_err_o = err_q;
`else
        bus.wbm_ack_o = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign bus.wbm_dat_o = rdat_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      adr_q  <= '0;
      dat_q  <= 32'h0;
      we_q   <= 1'b0;
      pend_q <= 4'b0000;
      rdat_q <= 32'h0;
    end else if (state == IDLE) begin
      if (start) begin
        adr_q  <= bus.wbm_adr_i;
        dat_q  <= bus.wbm_dat_i;
        we_q   <= bus.wbm_we_i;
        // Offset 0 is the most significant select bit.
        pend_q <= {bus.wbm_sel_i[0], bus.wbm_sel_i[1], bus.wbm_sel_i[2], bus.wbm_sel_i[3]};
        rdat_q <= 32'h0;
      end
    end else if (busy_live && byte_done) begin
      pend_q <= pend_nxt;
      if (!we_q) begin
        case (off)
          2'd0:    rdat_q[31:24] <= bus.wbs_dat_i;
          2'd1:    rdat_q[23:16] <= bus.wbs_dat_i;
          2'd2:    rdat_q[15:8]  <= bus.wbs_dat_i;
          default: rdat_q[7:0]   <= bus.wbs_dat_i;
        endcase
      end
    end
  end

`ifdef WB_DOWNSIZER_ERR_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                       err_q <= 1'b0;
    else if ((state == IDLE) && start)    err_q <= 1'b0;
    else if (busy_live && slv_err)        err_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_wb_downsizer.sv
// tb/tb_wb_downsizer.sv - directed scoreboard bench for wb_downsizer
module tb_wb_downsizer;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [7:0]  wdat;
    logic [7:0]  rdat;
  } sacc_t;

  logic clk;
  logic rst_n;
  int   vec = 0;
  int   mis = 0;

  sacc_t exp_q[$];
  int    slv_wait = 0;
  int    err_at = 0;
  int    acc_n = 0;
  int    cyc_seen = 0;
  int    wcnt = 0;

  wb_downsizer_if #(.aw(32)) bus ();

  wb_downsizer #(.aw(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-wide slave: acks after slv_wait wait cycles, checks each access against the queue.
  initial begin
    sacc_t e;
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;
    bus.wbs_dat_i = 8'h00;
    forever begin
      @(negedge clk);
      bus.wbs_ack_i = 1'b0;
      bus.wbs_err_i = 1'b0;
      if (bus.wbs_cyc_o && bus.wbs_stb_o) begin
        cyc_seen++;
        if (wcnt == slv_wait) begin
          wcnt = 0;
          if (acc_n + 1 == err_at) bus.wbs_err_i = 1'b1;
          else                     bus.wbs_ack_i = 1'b1;
          acc_n++;
          if (exp_q.size() == 0) begin
            check("slave_unexpected_access", 64'(exp_q.size()), 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("slave_adr", 64'(bus.wbs_adr_o), 64'(e.adr));
            check("slave_we", 64'(bus.wbs_we_o), 64'(e.we));
            if (e.we) check("slave_wdat", 64'(bus.wbs_dat_o), 64'(e.wdat));
            bus.wbs_dat_i = e.rdat;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Queue the byte accesses the slave should see; returns expected read word and byte count.
  task automatic push_bytes(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, input logic [31:0] rd, input int maxn,
                            output logic [31:0] exp_dat, output int n);
    sacc_t e;
    exp_dat = 32'h0;
    n = 0;
    for (int o = 0; o < 4; o++) begin
      if (sel[3-o] && n < maxn) begin
        e.adr  = {adr[31:2], 2'(o)};
        e.we   = we;
        e.wdat = dat[8*(3-o) +: 8];
        e.rdat = rd[8*(3-o) +: 8];
        if (!we) exp_dat[8*(3-o) +: 8] = rd[8*(3-o) +: 8];
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
    bus.wbm_adr_i = adr;
    bus.wbm_dat_i = dat;
    bus.wbm_sel_i = sel;
    bus.wbm_we_i  = we;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
  endtask

  task automatic release_master();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we, input logic [31:0] rd,
                      input int maxn, input logic exp_ack, input logic exp_err, input int exp_lat);
    logic [31:0] exp_dat;
    int n;
    int cnt;
    logic got;
    logic ack_s, err_s;
    logic [31:0] dat_s;
    @(negedge clk);
    acc_n = 0;
    cyc_seen = 0;
    push_bytes(adr, dat, sel, we, rd, maxn, exp_dat, n);
    drive(adr, dat, sel, we);
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      if (bus.wbm_ack_o || bus.wbm_err_o) got = 1'b1;
    end
    ack_s = bus.wbm_ack_o;
    err_s = bus.wbm_err_o;
    dat_s = bus.wbm_dat_o;
    release_master();
    check({tag, "_response_seen"}, 64'(got), 64'(1));
    check({tag, "_ack"}, 64'(ack_s), 64'(exp_ack));
    check({tag, "_err"}, 64'(err_s), 64'(exp_err));
    // The master takes the response on the edge after it becomes visible here.
    check({tag, "_latency"}, 64'(cnt + 1), 64'(exp_lat));
    if (!we) check({tag, "_rdata"}, 64'(dat_s), 64'(exp_dat));
    check({tag, "_slave_accesses"}, 64'(acc_n), 64'(n));
    check({tag, "_slave_cycles"}, 64'(cyc_seen), 64'(n * (slv_wait + 1)));
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_single_pulse"}, 64'({bus.wbm_ack_o, bus.wbm_err_o}), 64'(0));
  endtask

  initial begin
    logic [31:0] ed;
    int n;
    logic seen;
    rst_n = 1'b0;
    bus.wbm_adr_i = 32'h0;
    bus.wbm_dat_i = 32'h0;
    bus.wbm_sel_i = 4'h0;
    bus.wbm_we_i  = 1'b0;
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_master_outputs", 64'({bus.wbm_dat_o, bus.wbm_ack_o, bus.wbm_err_o}), 64'(0));
    check("reset_slave_outputs",
          64'({bus.wbs_adr_o, bus.wbs_dat_o, bus.wbs_we_o, bus.wbs_cyc_o, bus.wbs_stb_o}), 64'(0));
    rst_n = 1'b1;

    xfer("full_write", 32'h100, 32'hA1B2C3D4, 4'hF, 1'b1, 32'h0, 4, 1'b1, 1'b0, 6);
    xfer("sparse_read", 32'h204, 32'h0, 4'h5, 1'b0, 32'h00110022, 4, 1'b1, 1'b0, 4);
    repeat (3) @(negedge clk);
    check("rdata_hold", 64'(bus.wbm_dat_o), 64'(32'h00110022));
    xfer("full_read", 32'h2F0, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 4, 1'b1, 1'b0, 6);
    xfer("empty_sel", 32'h300, 32'h12345678, 4'h0, 1'b1, 32'h0, 4, 1'b1, 1'b0, 2);

    err_at = 2;
`ifdef WB_DOWNSIZER_ERR_EN
    xfer("slave_err", 32'h340, 32'h01020304, 4'hF, 1'b1, 32'h0, 2, 1'b0, 1'b1, 4);
`else
    xfer("slave_err_as_ack", 32'h340, 32'h01020304, 4'hF, 1'b1, 32'h0, 4, 1'b1, 1'b0, 6);
`endif
    err_at = 0;

    slv_wait = 3;
    xfer("wait_states", 32'h380, 32'h0, 4'hC, 1'b0, 32'h5566AABB, 4, 1'b1, 1'b0, 10);

    // Master drops its cycle while the second byte is waiting on the slave.
    @(negedge clk);
    acc_n = 0;
    push_bytes(32'h400, 32'h5A6B7C8D, 4'hF, 1'b1, 32'h0, 1, ed, n);
    drive(32'h400, 32'h5A6B7C8D, 4'hF, 1'b1);
    for (int i = 0; i < 40 && acc_n < 1; i++) @(negedge clk);
    check("abort_first_byte", 64'(acc_n), 64'(1));
    @(negedge clk);
    check("abort_second_adr", 64'(bus.wbs_adr_o), 64'(32'h401));
    release_master();
    @(negedge clk);
    check("abort_cyc_dropped", 64'(bus.wbs_cyc_o), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wbm_ack_o || bus.wbm_err_o || bus.wbs_cyc_o) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_ack", 64'(seen), 64'(0));
    check("abort_accesses", 64'(acc_n), 64'(1));

    // Reset pulled between clock edges in the middle of a byte.
    acc_n = 0;
    drive(32'h500, 32'hCAFEF00D, 4'hF, 1'b1);
    @(negedge clk);
    check("rst_mid_busy", 64'(bus.wbs_cyc_o), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({bus.wbs_adr_o, bus.wbs_dat_o, bus.wbs_we_o, bus.wbs_cyc_o, bus.wbs_stb_o,
               bus.wbm_ack_o, bus.wbm_err_o}), 64'(0));
    check("rst_async_rdata", 64'(bus.wbm_dat_o), 64'(0));
    release_master();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.wbm_ack_o || bus.wbm_err_o || bus.wbs_cyc_o) seen = 1'b1;
    end
    check("rst_no_ack_after", 64'(seen), 64'(0));
    check("rst_no_slave_access", 64'(acc_n), 64'(0));

    slv_wait = 0;
    xfer("post_reset_write", 32'h600, 32'h11223344, 4'h9, 1'b1, 32'h0, 4, 1'b1, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/wb_downsizer.md
WB_DOWNSIZER -- requirements
Module: wb_downsizer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter aw, default 32, SHALL set the address width of both ports.
REQ-003 Port wb_clk_i, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-004 Port wb_rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 Master-side inputs SHALL be:
- wbm_adr_i [aw]: byte address
- wbm_dat_i [32]: write data
- wbm_sel_i [4]: byte selects
- wbm_we_i [1]: write enable
- wbm_cyc_i [1]: cycle
- wbm_stb_i [1]: strobe
REQ-006 Master-side outputs SHALL be wbm_dat_o [32] (read data), wbm_ack_o [1] (acknowledge) and wbm_err_o [1] (error).
REQ-007 Slave-side outputs SHALL be:
- wbs_adr_o [aw]: byte address
- wbs_dat_o [8]: write byte
- wbs_we_o [1]: write enable
- wbs_cyc_o [1]: cycle
- wbs_stb_o [1]: strobe
REQ-008 Slave-side inputs SHALL be wbs_dat_i [8] (read byte), wbs_ack_i [1] (acknowledge) and wbs_err_i [1] (error).

Function
REQ-009 The block SHALL split each 32-bit classic Wishbone master access into one 8-bit slave access per set bit of wbm_sel_i.
REQ-010 Byte order SHALL be big-endian:
- sel[3] maps to offset 0 and data[31:24]
- sel[0] maps to offset 3 and data[7:0]
REQ-011 Bytes SHALL be issued in ascending offset order.
REQ-012 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-013 In IDLE, wbm_cyc_i&wbm_stb_i SHALL latch adr, dat, sel and we.
- If sel is nonzero, the next state SHALL be BUSY.
- If sel is zero, the next state SHALL be DONE with no slave access.
REQ-014 In BUSY, wbs_cyc_o and wbs_stb_o SHALL be 1, with:
- wbs_adr_o = {adr[aw-1:2], offset}
- wbs_dat_o = latched byte at that offset
- wbs_we_o = latched we
REQ-015 On wbs_ack_i in BUSY:
- On reads, wbs_dat_i SHALL be stored into the matching lane of wbm_dat_o.
- The offset SHALL advance to the next set sel bit, with the new address and data driven in the following cycle.
- After the last set bit, the next state SHALL be DONE and wbs_cyc_o/wbs_stb_o SHALL deassert.
REQ-016 In DONE, wbm_ack_o (or wbm_err_o) SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-017 Latency: with zero-wait slaves, a master access with N selected bytes SHALL acknowledge N+2 cycles after the strobe is sampled, and a sel=0 access 2 cycles after.
REQ-018 Lanes of wbm_dat_o for unselected bytes SHALL read 0.
- wbm_dat_o SHALL hold its value until the next access is latched.
REQ-019 If wbm_cyc_i deasserts in BUSY, the slave cycle SHALL be dropped in the next cycle and the state SHALL return to IDLE with no master acknowledge.
REQ-020 In IDLE, wbs_ack_i and wbs_err_i SHALL be ignored.
REQ-021 wbm_ack_o and wbm_err_o SHALL never both be 1 in the same cycle.

Reset
REQ-022 While wb_rst_ni=0, the state SHALL be IDLE and all outputs SHALL be 0, including wbm_dat_o=0 and wbs_adr_o=0.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer immediately, with no acknowledge after reset release.
REQ-024 The first access SHALL be latched no earlier than the first rising edge after wb_rst_ni rises.

Configuration
REQ-025 With WB_DOWNSIZER_ERR_EN defined:
- wbs_err_i in BUSY SHALL abort the remaining bytes and enter DONE.
- DONE SHALL then assert wbm_err_o instead of wbm_ack_o.
REQ-026 Without WB_DOWNSIZER_ERR_EN:
- wbs_err_i in BUSY SHALL be treated as wbs_ack_i.
- wbm_err_o SHALL be tied to 0.

Verification
REQ-027 Full-word write: write adr=0x100, dat=0xA1B2C3D4, sel=0xF -> slave writes 0xA1@0x100, 0xB2@0x101, 0xC3@0x102, 0xD4@0x103, then one wbm_ack_o pulse 6 cycles after the strobe.
REQ-028 Sparse read: read adr=0x204, sel=0x5, slave returns 0x11 then 0x22 -> slave reads at 0x205 and 0x207, and wbm_dat_o=0x00110022 with ack.
REQ-029 Empty select: sel=0x0 -> no wbs_cyc_o, and wbm_ack_o 2 cycles after the strobe.
REQ-030 Slave error (macro defined): sel=0xF with wbs_err_i on the 2nd byte -> only 2 slave accesses, and one wbm_err_o pulse with wbm_ack_o=0.
REQ-031 Abort and reset: wbm_cyc_i dropped during byte 2 -> wbs_cyc_o=0 the next cycle with no ack; wb_rst_ni pulled low mid-byte -> all outputs 0 asynchronously.
REQ-032 Wait states: slave inserts 3 wait cycles per byte with sel=0xC -> bytes at offsets 0 and 1 only, and ack 10 cycles after the strobe.
